// File: rtl/uart_tx_framer_pkg.sv
// Shared types and constants for the UART transmit path.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_package;

    localparam int UART_DEFAULT_WAIT = 868;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous show-ahead FIFO; dout always presents the head entry.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// FIFO-fed UART transmitter with configurable width, stop bits and parity.
// UART_TX_PARITY_EN compiles in the parity state and generator.
module uart_tx_framer
    import uart_package::*;
#(
    parameter int WAIT      = UART_DEFAULT_WAIT,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = PARITY_NONE,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send_req,
    input  logic [DATA_BITS-1:0] data,
    output logic                 full,
    output logic                 overflow,
    output logic                 busy,
    output logic                 uart_tx,
    output uart_tx_state_t       dbg_state
);

    localparam int CW = $clog2(WAIT);
    localparam int IW = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(WAIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    if (WAIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < PARITY_NONE || PARITY > PARITY_ODD || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_framer: illegal parameter combination");
    end

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;

    logic [CW-1:0]        r_baud;
    logic [CW-1:0]        w_baud_next;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_overflow;

    logic                 w_baud_end;
    logic                 w_load;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_head;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (send_req),
        .pop   (w_load),
        .din   (data),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY != PARITY_NONE);

    logic r_par;
    logic w_par_next;

    // Parity is latched with the word so the DATA shifts cannot disturb it.
    always_comb begin
        w_par_next = r_par;
        if (w_load) begin
            w_par_next = (^w_fifo_head) ^ (PARITY == PARITY_ODD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_next;
        end
    end
`endif

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_load       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load = !w_fifo_empty;
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_idx == DATA_LAST) begin
                        w_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = PAR_ON ? ST_PARITY : ST_STOP;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = ST_STOP;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_idx == STOP_LAST) begin
                        w_idx_next = '0;
                        if (w_fifo_empty) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A pop from IDLE or from the final stop bit both begin a fresh frame.
        if (w_load) begin
            w_state_next = ST_START;
            w_baud_next  = '0;
            w_idx_next   = '0;
            w_shift_next = w_fifo_head;
        end
    end

    // Line level is computed from the next state so uart_tx is a plain flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_par_next;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_idx      <= w_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_overflow <= send_req && w_fifo_full;
        end
    end

    assign uart_tx   = r_tx;
    assign overflow  = r_overflow;
    assign full      = w_fifo_full;
    assign busy      = !w_fifo_empty || (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: three instances (no parity, even/1 stop,
// odd/2 stop) compared against a bit-list frame model built from each word.
module tb_uart_tx_framer;
  import uart_package::*;

  localparam int WAIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic req0, req1, req2;
  logic [7:0] d0, d1, d2;
  logic full0, ov0, busy0, tx0;
  logic full1, ov1, busy1, tx1;
  logic full2, ov2, busy2, tx2;
  uart_tx_state_t st0, st1, st2;

  int total = 0;
  int bad = 0;
  int sel = 0;

  logic [7:0] exp_q[$];
  logic [7:0] push_q[$];
  logic exp_bits[$];

  logic mon_tx;
  logic mon_busy;

  uart_tx_framer #(.WAIT(WAIT), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .DEPTH(4)) u_main (
    .clk(clk), .reset(reset), .send_req(req0), .data(d0), .full(full0),
    .overflow(ov0), .busy(busy0), .uart_tx(tx0), .dbg_state(st0));

  uart_tx_framer #(.WAIT(WAIT), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .DEPTH(4)) u_even (
    .clk(clk), .reset(reset), .send_req(req1), .data(d1), .full(full1),
    .overflow(ov1), .busy(busy1), .uart_tx(tx1), .dbg_state(st1));

  uart_tx_framer #(.WAIT(WAIT), .DATA_BITS(8), .STOP_BITS(2), .PARITY(2), .DEPTH(4)) u_odd (
    .clk(clk), .reset(reset), .send_req(req2), .data(d2), .full(full2),
    .overflow(ov2), .busy(busy2), .uart_tx(tx2), .dbg_state(st2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always_comb begin
    mon_tx = tx0;
    mon_busy = busy0;
    if (sel == 1) begin
      mon_tx = tx1;
      mon_busy = busy1;
    end else if (sel == 2) begin
      mon_tx = tx2;
      mon_busy = busy2;
    end
  end

  // reference model: expected line bits of one frame, in send order
  function automatic void build_bits(input logic [7:0] w, input int s);
    int mode;
    int stops;
    mode = (s == 1) ? 1 : (s == 2) ? 2 : 0;
    stops = (s == 2) ? 2 : 1;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
    if (PAR_EN && mode != 0) begin
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += w[i];
      exp_bits.push_back((mode == 1) ? ones % 2 == 1 : ones % 2 == 0);
    end
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
  endfunction

  // driver tasks
  task automatic set_req(input int s, input logic r, input logic [7:0] d);
    case (s)
      1: begin req1 = r; d1 = d; end
      2: begin req2 = r; d2 = d; end
      default: begin req0 = r; d0 = d; end
    endcase
  endtask

  task automatic push_burst(input int s);
    while (push_q.size() > 0) begin
      set_req(s, 1'b1, push_q.pop_front());
      @(negedge clk);
    end
    set_req(s, 1'b0, 8'h00);
  endtask

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (mon_tx === 1'b0) begin
        cyc = i;
        return;
      end
    end
  endtask

  // scoreboard: current negedge is the first start-bit sample
  task automatic check_stream(input int nfr, input string name);
    int busy_bad;
    bit first;
    logic [7:0] w;
    busy_bad = 0;
    first = 1'b1;
    for (int f = 0; f < nfr; f++) begin
      if (exp_q.size() == 0) break;
      w = exp_q.pop_front();
      build_bits(w, sel);
      for (int b = 0; b < exp_bits.size(); b++) begin
        int errs;
        logic got;
        errs = 0;
        got = exp_bits[b];
        for (int c = 0; c < WAIT; c++) begin
          if (!first) @(negedge clk);
          first = 1'b0;
          if (mon_tx !== exp_bits[b]) begin
            errs++;
            got = mon_tx;
          end
          if (mon_busy !== 1'b1) busy_bad++;
        end
        total++;
        if (errs != 0) begin
          bad++;
          $display("FAIL %s frame%0d bit%0d: got %b in %0d of %0d cycles, want %b",
                   name, f, b, got, errs, WAIT, exp_bits[b]);
        end
      end
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s busy_during_frames: low in %0d cycles, want 0", name, busy_bad);
    end
    @(negedge clk);
    total++;
    if (mon_busy !== 1'b0 || mon_tx !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_fall: busy=%b tx=%b, want busy=0 tx=1", name, mon_busy, mon_tx);
    end
  endtask

  task automatic run_frames(input int nfr, input string name);
    int cyc;
    wait_start(cyc);
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL %s start_timeout: no start bit in 64 cycles, want one", name);
      exp_q.delete();
    end else begin
      check_stream(nfr, name);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    set_req(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    total++; if (full0 !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full0); end
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ov0); end
    total++; if (st0 !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", st0, ST_IDLE); end
    total++; if (tx1 !== 1'b1 || tx2 !== 1'b1) begin
      bad++; $display("FAIL reset_tx_others: got %b%b want 11", tx1, tx2);
    end
  endtask

  task automatic test_single();
    int cyc;
    sel = 0;
    exp_q.delete();
    exp_q.push_back(8'h5A);
    set_req(0, 1'b1, 8'h5A);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL single_busy_after_push: got %b want 1", busy0); end
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL single_tx_after_push: got %b want 1", tx0); end
    wait_start(cyc);
    total++;
    if (cyc != 1) begin
      bad++;
      $display("FAIL single_start_latency: got %0d cycles want 1", cyc);
    end
    if (cyc > 0) check_stream(1, "single");
  endtask

  task automatic test_back_to_back();
    sel = 0;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    push_q.push_back(8'h55);
    push_q.push_back(8'hAA);
    fork
      push_burst(0);
      run_frames(2, "b2b");
    join
  endtask

  task automatic test_overflow();
    logic [7:0] w[6];
    sel = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      if (i < 5) exp_q.push_back(w[i]);
    end
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          set_req(0, 1'b1, w[i]);
          @(negedge clk);
          if (i == 4) begin
            total++; if (full0 !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full0); end
            total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL ovf_early_pulse: got %b want 0", ov0); end
          end
        end
        set_req(0, 1'b0, 8'h00);
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", ov0); end
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL ovf_pulse_width: got %b want 0", ov0); end
      end
      run_frames(5, "ovf");
    join
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      int n;
      sel = s;
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        exp_q.push_back(w);
        push_q.push_back(w);
      end
      fork
        push_burst(s);
        run_frames(n, (s == 0) ? "rand_main" : "rand_even");
      join
    end
  endtask

  task automatic test_parity();
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      exp_q.delete();
      exp_q.push_back(8'h07);
      push_q.push_back(8'h07);
      fork
        push_burst(s);
        run_frames(1, (s == 1) ? "parity_even" : "parity_odd_2stop");
      join
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) push_q.push_back(8'($urandom_range(0, 255)));
    fork
      push_burst(0);
      begin
        int cyc;
        int lows;
        wait_start(cyc);
        total++;
        if (cyc < 0) begin
          bad++;
          $display("FAIL rstmid_start_timeout: no start bit in 64 cycles, want one");
        end else begin
          repeat (34) @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx0); end
          total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
          total++; if (full0 !== 1'b0) begin bad++; $display("FAIL rstmid_full: got %b want 0", full0); end
          lows = 0;
          repeat (200) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
          end
          total++;
          if (lows != 0) begin
            bad++;
            $display("FAIL rstmid_quiet: line low for %0d cycles want 0", lows);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random();
    test_parity();
    test_reset_mid();
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
